// File: rtl/seg7_axil_regs.sv
// -----------------------------------------------------------------------------
// seg7_axil_regs
//
// AXI4-Lite register slave that holds the value shown on an 8-digit
// seven-segment display.
//
// Register map (decoded on addr[3:2], addr[1:0] ignored):
//   0x0 DATA  - hex digits shown on the display
//   0x4 ALT   - alternate digits shown in the blink phase   (blink build only)
//   0x8 CTRL  - bit0 BLINK, other bits read as 0            (blink build only)
//   0xC       - unmapped: SLVERR response, reads return 0, writes ignored
//
// Build option:
//   SEG7_AXIL_BLINK_EN - adds ALT, CTRL and a BLINK_LOG2-bit free-running
//                        counter whose wrap toggles the blink phase. Without
//                        it, 0x4/0x8 read 0 with OKAY and writes to them are
//                        dropped with OKAY.
//
// Parameters:
//   RESET_VALUE - DATA (and seg_data) value after reset
//   BLINK_LOG2  - log2 of the blink half-period in clk cycles
//
// Ports:
//   clk, rst_n          - clock (rising edge) and asynchronous active-low reset
//   s_axi_aw*           - write address channel (4-bit address)
//   s_axi_w*            - write data channel (32-bit data, 4-bit strobe)
//   s_axi_b*            - write response channel
//   s_axi_ar*           - read address channel (4-bit address)
//   s_axi_r*            - read data channel
//   seg_data            - registered digits, digit i at bits [4i+3:4i]
// -----------------------------------------------------------------------------
module seg7_axil_regs #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
    parameter int          BLINK_LOG2  = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [3:0]  s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] seg_data
);

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_ALT  = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_NONE = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Merge new bytes into an old word under a byte-enable mask.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic        aw_vld_q, aw_vld_d;
    logic [1:0]  aw_reg_q, aw_reg_d;
    logic        w_vld_q,  w_vld_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q,  bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [1:0]  rresp_q,  rresp_d;
    logic [31:0] data_q,   data_d;
    logic [31:0] seg_q,    seg_d;

`ifdef SEG7_AXIL_BLINK_EN
    logic [31:0]           alt_q,   alt_d;
    logic                  ctrl_q,  ctrl_d;
    logic [BLINK_LOG2-1:0] cnt_q,   cnt_d;
    logic                  phase_q, phase_d;
`endif

    logic commit;

    // Ready signals come straight from state; the latches stay set while the
    // response is pending, which also keeps a second write from starting.
    assign s_axi_awready = !aw_vld_q && !bvalid_q;
    assign s_axi_wready  = !w_vld_q  && !bvalid_q;
    assign s_axi_arready = !rvalid_q;

    assign commit = aw_vld_q && w_vld_q && !bvalid_q;

    always_comb begin
        aw_vld_d = aw_vld_q;
        aw_reg_d = aw_reg_q;
        w_vld_d  = w_vld_q;
        w_data_d = w_data_q;
        w_strb_d = w_strb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        data_d   = data_q;
`ifdef SEG7_AXIL_BLINK_EN
        alt_d    = alt_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q + {{(BLINK_LOG2-1){1'b0}}, 1'b1};
        phase_d  = (&cnt_q) ? !phase_q : phase_q;
`endif

        if (s_axi_awvalid && s_axi_awready) begin
            aw_vld_d = 1'b1;
            aw_reg_d = s_axi_awaddr[3:2];
        end
        if (s_axi_wvalid && s_axi_wready) begin
            w_vld_d  = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end

        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = (aw_reg_q == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
            case (aw_reg_q)
                REG_DATA: data_d = apply_strb(data_q, w_data_q, w_strb_q);
`ifdef SEG7_AXIL_BLINK_EN
                REG_ALT:  alt_d  = apply_strb(alt_q, w_data_q, w_strb_q);
                REG_CTRL: ctrl_d = w_strb_q[0] ? w_data_q[0] : ctrl_q;
`endif
                default: ;
            endcase
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
            aw_vld_d = 1'b0;
            w_vld_d  = 1'b0;
        end

        // The read samples registers before this cycle's commit lands, so a
        // read colliding with a write returns the old value.
        if (s_axi_arvalid && s_axi_arready) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            case (s_axi_araddr[3:2])
                REG_DATA: rdata_d = data_q;
`ifdef SEG7_AXIL_BLINK_EN
                REG_ALT:  rdata_d = alt_q;
                REG_CTRL: rdata_d = {31'b0, ctrl_q};
`else
                REG_ALT:  rdata_d = 32'h0;
                REG_CTRL: rdata_d = 32'h0;
`endif
                default: begin
                    rdata_d = 32'h0;
                    rresp_d = RESP_SLVERR;
                end
            endcase
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end

        // Built from the registered DATA so the display follows a commit by
        // exactly one cycle.
        seg_d = data_q;
`ifdef SEG7_AXIL_BLINK_EN
        if (ctrl_q && phase_q) begin
            seg_d = alt_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_vld_q <= 1'b0;
            aw_reg_q <= 2'd0;
            w_vld_q  <= 1'b0;
            w_data_q <= 32'h0;
            w_strb_q <= 4'h0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            rresp_q  <= 2'b00;
            data_q   <= RESET_VALUE;
            seg_q    <= RESET_VALUE;
`ifdef SEG7_AXIL_BLINK_EN
            alt_q    <= 32'h0;
            ctrl_q   <= 1'b0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
`endif
        end else begin
            aw_vld_q <= aw_vld_d;
            aw_reg_q <= aw_reg_d;
            w_vld_q  <= w_vld_d;
            w_data_q <= w_data_d;
            w_strb_q <= w_strb_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            data_q   <= data_d;
            seg_q    <= seg_d;
`ifdef SEG7_AXIL_BLINK_EN
            alt_q    <= alt_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
`endif
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign seg_data     = seg_q;

    // Byte-offset address bits carry no meaning here; BLINK_LOG2 only matters
    // in the blink build.
    logic unused_ok;
`ifdef SEG7_AXIL_BLINK_EN
    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], (BLINK_LOG2 != 0)};
`endif

endmodule

// File: doc/seg7_axil_regs.md
SEG7_AXIL_REGS -- requirements
Module: seg7_axil_regs

Interface
REQ-001 The block SHALL have parameter RESET_VALUE, default 32'h0000_0000, the DATA register value after reset.
REQ-002 The block SHALL have parameter BLINK_LOG2, default 24, the log2 of the blink half-period in clk cycles (used only with SEG7_AXIL_BLINK_EN).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have ports s_axi_awaddr (input, 4 bits), s_axi_awvalid (input, 1 bit) and s_axi_awready (output, 1 bit), forming the AXI4-Lite write address channel.
REQ-006 The block SHALL have ports s_axi_wdata (input, 32 bits), s_axi_wstrb (input, 4 bits), s_axi_wvalid (input, 1 bit) and s_axi_wready (output, 1 bit), forming the write data channel.
REQ-007 The block SHALL have ports s_axi_bresp (output, 2 bits), s_axi_bvalid (output, 1 bit) and s_axi_bready (input, 1 bit), forming the write response channel.
REQ-008 The block SHALL have ports s_axi_araddr (input, 4 bits), s_axi_arvalid (input, 1 bit) and s_axi_arready (output, 1 bit), forming the read address channel.
REQ-009 The block SHALL have ports s_axi_rdata (output, 32 bits), s_axi_rresp (output, 2 bits), s_axi_rvalid (output, 1 bit) and s_axi_rready (input, 1 bit), forming the read data channel.
REQ-010 The block SHALL have port seg_data, output, 32 bits, the 8 hex nibbles fed to the seven-segment display driver, with digit i at bits [4i+3:4i].

Function
REQ-011 The register map SHALL be decoded on addr[3:2]: 0x0 DATA, 0x4 ALT, 0x8 CTRL (bit0 BLINK, bits 31:1 read 0), 0xC unmapped; addr[1:0] are ignored.
REQ-012 AW and W SHALL be accepted independently: awready is high while no address is latched and bvalid is low, and wready follows the same rule for write data.
REQ-013 A write SHALL commit in the cycle after both AW and W are latched, updating only the bytes whose wstrb bit is set, and bvalid SHALL assert in that same cycle.
REQ-014 bvalid SHALL hold, with bresp stable, until bready is high; the AW/W latches then clear and awready/wready return high on the next cycle.
REQ-015 Only one write SHALL be outstanding at a time, and awready/wready SHALL be low while bvalid is high.
REQ-016 arready SHALL be high only when rvalid is low; an AR handshake SHALL produce rvalid on the next cycle with rdata captured at handshake time.
REQ-017 rvalid, rdata and rresp SHALL hold until rready is high; a new AR SHALL be accepted no earlier than the cycle after the R handshake.
REQ-018 bresp/rresp SHALL be 2'b00 (OKAY) for mapped offsets and 2'b10 (SLVERR) for 0xC; an SLVERR write SHALL modify no state; reads of 0xC SHALL return 0.
REQ-019 When a write and a read of the same register occur in the same cycle, the read SHALL return the pre-write value.
REQ-020 seg_data SHALL be registered and SHALL reflect a committed write to DATA exactly one cycle after the commit cycle.

Reset
REQ-021 On rst_n low, regardless of clock: DATA=RESET_VALUE, ALT=0, CTRL=0, blink counter=0, phase=0, AW/W latches clear, bvalid=rvalid=0, bresp=rresp=0, rdata=0, seg_data=RESET_VALUE.
REQ-022 Reset mid-transaction SHALL discard any latched AW/W and pending response, and awready, wready and arready SHALL be high in the first cycle after rst_n deasserts.

Configuration
REQ-023 With macro SEG7_AXIL_BLINK_EN defined, a BLINK_LOG2-bit free-running counter SHALL toggle phase on wrap; when CTRL.BLINK=1, seg_data SHALL be DATA in phase 0 and ALT in phase 1; when CTRL.BLINK=0, seg_data SHALL be DATA.
REQ-024 Without SEG7_AXIL_BLINK_EN, ALT and CTRL and the counter SHALL not exist, offsets 0x4/0x8 SHALL read 0 with OKAY, writes to them SHALL be ignored with OKAY, and seg_data SHALL equal DATA.

Verification
REQ-025 Reset release -> seg_data=32'h0000_0000, bvalid=rvalid=0, awready=wready=arready=1.
REQ-026 W(0x1234_5678, strb 4'hF) two cycles before AW(0x0) -> bvalid/OKAY on the commit cycle after AW; seg_data=32'h1234_5678 one cycle later.
REQ-027 DATA=0x1234_5678, then write 0xAABB_CCDD strb 4'b0101 to 0x0 -> seg_data=32'h12BB_56DD; read 0x0 returns the same.
REQ-028 Read 0xC with rready held low 5 cycles -> rvalid stays 1, rresp=2'b10, rdata=0, arready=0 until rready.
REQ-029 With SEG7_AXIL_BLINK_EN and BLINK_LOG2=3: DATA=0x1111_1111, ALT=0x2222_2222, CTRL=1 -> seg_data alternates every 8 cycles; without the macro, reading 0x4 returns 0 (OKAY).
REQ-030 Assert rst_n low while bvalid=1 and bready=0 -> bvalid=0 immediately; DATA returns to RESET_VALUE.
